// File: rtl/rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_buffer
// Brief    : Receive frame buffer between an HDLC-style deframer and a host.
//            Stores frames in a circular byte RAM and commits only FCS-good
//            frames, whose payload lengths go into a small length queue.
// Revision : 1.0 - initial release
// ============================================================================
module rx_frame_buffer #(
  parameter int AW    = 8,
  parameter int LQ_AW = 2
) (
  input  logic          netclk,
  input  logic          reset,
  input  logic          byte_ready,
  input  logic [7:0]    din,
  input  logic          frame_complete,
  input  logic          frame_valid,
  input  logic          frame_abort,
  input  logic          rd_en,
  input  logic          frame_pop,
  output logic          frame_avail,
  output logic [AW:0]   frame_len,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [7:0]    crc_err_cnt,
  output logic [7:0]    abort_cnt,
  output logic [7:0]    ovf_cnt
);

  localparam int            c_DEPTH    = 1 << AW;
  localparam int            c_LQ_DEPTH = 1 << LQ_AW;
  localparam logic [AW:0]   c_RAM_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   c_ONE      = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   c_FCS_LEN  = {{(AW-1){1'b0}}, 2'b10};
  localparam logic [AW:0]   c_MIN_LEN  = {{(AW-1){1'b0}}, 2'b11};
  localparam logic [LQ_AW:0] c_LQ_FULL = {1'b1, {LQ_AW{1'b0}}};
  localparam logic [LQ_AW:0] c_LQ_ONE  = {{LQ_AW{1'b0}}, 1'b1};
  localparam logic [LQ_AW-1:0] c_LQ_INC = {{(LQ_AW-1){1'b0}}, 1'b1};

  logic [7:0]       r_mem [c_DEPTH];
  logic [AW:0]      r_lq  [c_LQ_DEPTH];

  logic             r_byte_q;
  logic             r_fc_q;
  logic             r_abort_q;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_fs_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      r_rd_cnt;
  logic [AW:0]      r_cur_len;
  logic             r_cur_ovf;
  logic [LQ_AW-1:0] r_lq_head;
  logic [LQ_AW-1:0] r_lq_tail;
  logic [LQ_AW:0]   r_lq_cnt;
  logic [7:0]       r_crc_cnt;
  logic [7:0]       r_abort_cnt;
  logic [7:0]       r_ovf_cnt;
  logic [7:0]       r_rd_data;
  logic             r_rd_valid;

  logic             w_byte_edge;
  logic             w_fc_edge;
  logic             w_abort_edge;
  logic             w_ram_full;
  logic             w_wr_accept;
  logic             w_ovf_eff;
  logic [AW:0]      w_inc;
  logic [AW:0]      w_len_eff;
  logic [AW:0]      w_wr_eff;
  logic [AW:0]      w_commit_ptr;
  logic             w_len_ok;
  logic             w_lq_full;
  logic             w_fc_eval;
  logic             w_commit;
  logic             w_crc_drop;
  logic             w_ovf_drop;
  logic             w_close;
  logic             w_avail;
  logic [AW:0]      w_head_len;
  logic             w_pop;
  logic             w_rd;
  logic [AW:0]      w_rd_sum;
  logic [AW-1:0]    w_rd_addr;

  function automatic logic [7:0] f_sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_byte_edge  = byte_ready & ~r_byte_q;
  assign w_fc_edge    = frame_complete & ~r_fc_q;
  assign w_abort_edge = frame_abort & ~r_abort_q;

  // Space is measured against the head frame base so unread data is never overwritten.
  assign w_ram_full   = ((r_wr_ptr - r_rd_ptr) == c_RAM_FULL);
  assign w_wr_accept  = w_byte_edge & ~w_ram_full & ~r_cur_ovf;
  assign w_ovf_eff    = r_cur_ovf | (w_byte_edge & ~w_wr_accept);
  assign w_inc        = w_wr_accept ? c_ONE : '0;
  assign w_len_eff    = r_cur_len + w_inc;
  assign w_wr_eff     = r_wr_ptr + w_inc;
  assign w_commit_ptr = w_wr_eff - c_FCS_LEN;
  assign w_len_ok     = (w_len_eff >= c_MIN_LEN);
  assign w_lq_full    = (r_lq_cnt == c_LQ_FULL);

  // Abort wins over a simultaneous closing flag; the frame is dropped either way.
  assign w_fc_eval    = w_fc_edge & ~w_abort_edge;
  assign w_commit     = w_fc_eval & ~w_ovf_eff & w_len_ok & frame_valid & ~w_lq_full;
  assign w_crc_drop   = w_fc_eval & ~w_ovf_eff & w_len_ok & ~frame_valid;
  assign w_ovf_drop   = w_fc_eval & (w_ovf_eff | (w_len_ok & frame_valid & w_lq_full));
  assign w_close      = w_abort_edge | w_fc_edge;

  assign w_avail      = (r_lq_cnt != '0);
  assign w_head_len   = r_lq[r_lq_head];
  assign w_pop        = frame_pop & w_avail;
  assign w_rd         = rd_en & w_avail & ~frame_pop & (r_rd_cnt < w_head_len);
  assign w_rd_sum     = r_rd_ptr + r_rd_cnt;
  assign w_rd_addr    = w_rd_sum[AW-1:0];

  always_ff @(posedge netclk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge netclk) begin
    if (w_commit) begin
      r_lq[r_lq_tail] <= w_len_eff - c_FCS_LEN;
    end
  end

  always_ff @(posedge netclk or posedge reset) begin
    if (reset) begin
      r_byte_q    <= 1'b0;
      r_fc_q      <= 1'b0;
      r_abort_q   <= 1'b0;
      r_wr_ptr    <= '0;
      r_fs_ptr    <= '0;
      r_cur_len   <= '0;
      r_cur_ovf   <= 1'b0;
      r_crc_cnt   <= '0;
      r_abort_cnt <= '0;
      r_ovf_cnt   <= '0;
    end else begin
      r_byte_q  <= byte_ready;
      r_fc_q    <= frame_complete;
      r_abort_q <= frame_abort;
      if (w_close) begin
        r_cur_len <= '0;
        r_cur_ovf <= 1'b0;
        if (w_commit) begin
          r_wr_ptr <= w_commit_ptr;
          r_fs_ptr <= w_commit_ptr;
        end else begin
          r_wr_ptr <= r_fs_ptr;
        end
      end else begin
        r_wr_ptr  <= w_wr_eff;
        r_cur_len <= w_len_eff;
        r_cur_ovf <= w_ovf_eff;
      end
      if (w_abort_edge) r_abort_cnt <= f_sat_inc(r_abort_cnt);
      if (w_crc_drop)   r_crc_cnt   <= f_sat_inc(r_crc_cnt);
      if (w_ovf_drop)   r_ovf_cnt   <= f_sat_inc(r_ovf_cnt);
    end
  end

  // Length queue bookkeeping; a commit and a pop in one cycle cancel in the count.
  always_ff @(posedge netclk or posedge reset) begin
    if (reset) begin
      r_lq_head <= '0;
      r_lq_tail <= '0;
      r_lq_cnt  <= '0;
    end else begin
      if (w_commit) r_lq_tail <= r_lq_tail + c_LQ_INC;
      if (w_pop)    r_lq_head <= r_lq_head + c_LQ_INC;
      case ({w_commit, w_pop})
        2'b10:   r_lq_cnt <= r_lq_cnt + c_LQ_ONE;
        2'b01:   r_lq_cnt <= r_lq_cnt - c_LQ_ONE;
        default: r_lq_cnt <= r_lq_cnt;
      endcase
    end
  end

  always_ff @(posedge netclk or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_rd_cnt   <= '0;
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + w_head_len;
        r_rd_cnt <= '0;
      end else if (w_rd) begin
        r_rd_data <= r_mem[w_rd_addr];
        r_rd_cnt  <= r_rd_cnt + c_ONE;
      end
    end
  end

  assign frame_avail = w_avail;
  assign frame_len   = w_avail ? w_head_len : '0;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign crc_err_cnt = r_crc_cnt;
  assign abort_cnt   = r_abort_cnt;
  assign ovf_cnt     = r_ovf_cnt;

endmodule
`default_nettype wire

// File: doc/rx_frame_buffer.md
RX_FRAME_BUFFER -- requirements
Module: rx_frame_buffer

Interface
REQ-001 Parameter AW, default 8: log2 of data RAM depth in bytes (256).
REQ-002 Parameter LQ_AW, default 2: log2 of committed-frame length queue depth (4 entries).
REQ-003 netclk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 byte_ready  in  1  deframer byte strobe (level; may stay high several cycles).
REQ-006 din  in  8  deframer received byte, valid when byte_ready rises.
REQ-007 frame_complete  in  1  deframer closing-flag indication (level).
REQ-008 frame_valid  in  1  deframer FCS-good flag, sampled when frame_complete rises.
REQ-009 frame_abort  in  1  deframer abort indication (level).
REQ-010 rd_en  in  1  host read strobe, one byte per asserted cycle.
REQ-011 frame_pop  in  1  host pulse: discard head frame, advance to next.
REQ-012 frame_avail  out  1  at least one committed frame queued.
REQ-013 frame_len  out  AW+1  payload length of head frame, FCS excluded.
REQ-014 rd_data  out  8  registered read data.
REQ-015 rd_valid  out  1  rd_data valid this cycle.
REQ-016 crc_err_cnt, abort_cnt, ovf_cnt  out  8 each  saturating drop counters.

Function
REQ-017 Block SHALL detect rising edges of byte_ready, frame_complete and frame_abort against their values registered on the previous cycle; levels SHALL have no further effect.
REQ-018 Byte edge SHALL write din to RAM[wr_ptr], increment wr_ptr (AW+1 bits, wraps) and cur_len, unless RAM full ((wr_ptr - rd_ptr) == 2^AW) or cur_ovf is set; in that case cur_ovf SHALL be set and nothing written.
REQ-019 frame_complete edge with frame_valid=1, cur_ovf=0, cur_len>=3 and length queue not full SHALL commit: push cur_len-2 to length queue, set wr_ptr to wr_ptr-2 (FCS bytes dropped), set fs_ptr to that value.
REQ-020 frame_complete edge with frame_valid=0 and cur_len>=3 SHALL discard (wr_ptr <= fs_ptr) and increment crc_err_cnt.
REQ-021 frame_complete edge with cur_len<3 SHALL discard silently, no counter change (covers back-to-back flags).
REQ-022 frame_complete edge with cur_ovf=1, or length queue full, SHALL discard and increment ovf_cnt.
REQ-023 frame_abort edge SHALL discard the frame in progress and increment abort_cnt, even if cur_len=0.
REQ-024 Every commit or discard SHALL clear cur_len and cur_ovf; the next byte edge starts a new frame at fs_ptr.
REQ-025 All counters SHALL saturate at 255.
REQ-026 frame_avail SHALL equal length queue non-empty; frame_len SHALL show queue head, 0 when empty.
REQ-027 rd_en while frame_avail=1 and rd_cnt<frame_len SHALL drive rd_data <= RAM[rd_ptr+rd_cnt] and rd_valid=1 on the next cycle, and increment rd_cnt; otherwise rd_en ignored, rd_valid=0.
REQ-028 frame_pop while frame_avail=1 SHALL set rd_ptr <= rd_ptr+frame_len, rd_cnt <= 0, pop queue head; frame_pop while empty ignored.
REQ-029 frame_pop and rd_en in same cycle: pop executes, rd_en ignored.
REQ-030 Commit and frame_pop in same cycle SHALL both take effect; queue count unchanged, no entry lost.
REQ-031 Byte edge and frame_complete edge in same cycle: byte written first, then completion evaluated including it.
REQ-032 Uncommitted bytes SHALL never be readable; space check SHALL use rd_ptr (head frame base).

Reset
REQ-033 reset SHALL clear wr_ptr, fs_ptr, rd_ptr, rd_cnt, cur_len, cur_ovf, length queue, counters and edge registers; outputs: frame_avail=0, frame_len=0, rd_data=0x00, rd_valid=0.
REQ-034 Edge registers SHALL reset to 0, so inputs high at reset release register as edges on the first cycle.
REQ-035 Reset mid-frame or mid-read SHALL lose all buffered data; no partial state survives.

Verification
REQ-036 Bytes 0x01 0x02 0x03 + 2 FCS bytes, complete with frame_valid=1 -> frame_avail=1, frame_len=3, three rd_en give 0x01,0x02,0x03 one cycle later; fourth rd_en gives rd_valid=0.
REQ-037 Same frame with frame_valid=0 -> frame_avail stays 0, crc_err_cnt=1, wr_ptr back to 0.
REQ-038 Four bytes then frame_abort pulse, then valid 5-byte frame -> abort_cnt=1, frame_len=3, data from second frame only.
REQ-039 Five valid 4-byte frames with no pops -> four queued, fifth dropped, ovf_cnt=1; pop all -> frame_avail=0.
REQ-040 260-byte frame into empty RAM -> dropped, ovf_cnt=1; following 6-byte valid frame committed with frame_len=4.
REQ-041 byte_ready held high 3 cycles -> single write; reset asserted mid-read -> all outputs at reset values next edge.
